// File: rtl/renode_apb3_multi_requester.sv
// APB3 requester bridging one Renode request/response channel to NumSubordinates APB3
// subordinates, with region decode, a bounded wait-state timeout and a held response.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel of the decoded subordinate high, penable low
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | response presented until resp_ready
module renode_apb3_multi_requester #(
  parameter int AddressWidth        = 20,
  parameter int DataWidth           = 32,
  parameter int NumSubordinates     = 4,
  parameter int SubordinateAddrBits = 16,
  parameter int TimeoutCycles       = 1024
) (
  input  logic                                 pclk_i,
  input  logic                                 presetn_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_write_i,
  input  logic [AddressWidth-1:0]              req_addr_i,
  input  logic [DataWidth-1:0]                 req_wdata_i,
  output logic                                 resp_valid_o,
  input  logic                                 resp_ready_i,
  output logic [DataWidth-1:0]                 resp_rdata_o,
  output logic                                 resp_error_o,
  output logic                                 resp_timeout_o,
  output logic [AddressWidth-1:0]              paddr_o,
  output logic [NumSubordinates-1:0]           psel_o,
  output logic                                 penable_o,
  output logic                                 pwrite_o,
  output logic [DataWidth-1:0]                 pwdata_o,
  input  logic [NumSubordinates*DataWidth-1:0] prdata_i,
  input  logic [NumSubordinates-1:0]           pready_i,
  input  logic [NumSubordinates-1:0]           pslverr_i
);

  localparam int UpW  = AddressWidth - SubordinateAddrBits;
  // Region index zero-extended so it can be compared against any NumSubordinates up to 16.
  localparam int ExtW = UpW + 5;
  localparam int IdxW = (NumSubordinates > 1) ? $clog2(NumSubordinates) : 1;
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  if (!(DataWidth == 8 || DataWidth == 16 || DataWidth == 24 || DataWidth == 32)) begin : g_bad_data_width
    $error("DataWidth must be 8, 16, 24 or 32");
  end
  if (SubordinateAddrBits >= AddressWidth) begin : g_bad_region_bits
    $error("SubordinateAddrBits must be smaller than AddressWidth");
  end
  if (NumSubordinates < 1 || NumSubordinates > 16) begin : g_bad_num_subordinates
    $error("NumSubordinates must be in 1..16");
  end

  logic [1:0]                 state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [CntW-1:0]            wait_cnt_q, wait_cnt_d;
  logic                       req_ready_q, req_ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0]       resp_rdata_q, resp_rdata_d;
  logic                       resp_error_q, resp_error_d;
  logic                       resp_timeout_q, resp_timeout_d;
  logic [AddressWidth-1:0]    paddr_q, paddr_d;
  logic [NumSubordinates-1:0] psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [DataWidth-1:0]       pwdata_q, pwdata_d;

  logic [ExtW-1:0]            req_idx_ext;
  logic [NumSubordinates-1:0] req_onehot;
  logic                       decode_err;
  logic                       accept;
  logic                       sel_ready;
  logic                       sel_err;
  logic [DataWidth-1:0]       sel_rdata;

  assign req_idx_ext = ExtW'(req_addr_i[AddressWidth-1:SubordinateAddrBits]);
  assign decode_err  = (req_idx_ext >= ExtW'(NumSubordinates));
  assign accept      = req_valid_i && req_ready_q;
  assign sel_ready   = pready_i[idx_q];
  assign sel_err     = pslverr_i[idx_q];
  assign sel_rdata   = prdata_i[int'(idx_q)*DataWidth +: DataWidth];

  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NumSubordinates; i++) begin
      req_onehot[i] = (req_idx_ext == ExtW'(i));
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_cnt_d     = wait_cnt_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_error_d   = resp_error_q;
    resp_timeout_d = resp_timeout_q;
    paddr_d        = paddr_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    pwrite_d       = pwrite_q;
    pwdata_d       = pwdata_q;

    case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d    = 1'b0;
          paddr_d        = req_addr_i;
          pwrite_d       = req_write_i;
          pwdata_d       = req_wdata_i;
          idx_d          = req_idx_ext[IdxW-1:0];
          resp_rdata_d   = '0;
          resp_timeout_d = 1'b0;
          if (decode_err) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d      = StSetup;
            psel_d       = req_onehot;
            wait_cnt_d   = '0;
            resp_error_d = 1'b0;
          end
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (sel_ready) begin
          state_d      = StResp;
          psel_d       = '0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_error_d = sel_err;
          resp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (TimeoutCycles != 0 && wait_cnt_d == TimeoutVal) begin
            state_d        = StResp;
            psel_d         = '0;
            penable_d      = 1'b0;
            resp_valid_d   = 1'b1;
            resp_error_d   = 1'b1;
            resp_timeout_d = 1'b1;
            resp_rdata_d   = '0;
          end
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d        = StIdle;
          req_ready_d    = 1'b1;
          resp_valid_d   = 1'b0;
          resp_error_d   = 1'b0;
          resp_timeout_d = 1'b0;
          resp_rdata_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_error_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      paddr_q        <= '0;
      psel_q         <= '0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      pwdata_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_error_q   <= resp_error_d;
      resp_timeout_q <= resp_timeout_d;
      paddr_q        <= paddr_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      pwrite_q       <= pwrite_d;
      pwdata_q       <= pwdata_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_error_o   = resp_error_q;
  assign resp_timeout_o = resp_timeout_q;
  assign paddr_o        = paddr_q;
  assign psel_o         = psel_q;
  assign penable_o      = penable_q;
  assign pwrite_o       = pwrite_q;
  assign pwdata_o       = pwdata_q;

endmodule

// File: tb/tb_renode_apb3_multi_requester.sv
// Scoreboard bench for renode_apb3_multi_requester: a stimulus process plans each transfer and
// queues the expected response, a responder plays the subordinates, a monitor checks the outputs.
`timescale 1ns/1ps
module tb_renode_apb3_multi_requester;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SAB = 16;
  localparam int TO  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_wdata = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [DW-1:0]    resp_rdata;
  logic             resp_error;
  logic             resp_timeout;
  logic [AW-1:0]    paddr;
  logic [NS-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic [NS*DW-1:0] prdata = '0;
  logic [NS-1:0]    pready = '0;
  logic [NS-1:0]    pslverr = '0;

  renode_apb3_multi_requester #(
    .AddressWidth(AW), .DataWidth(DW), .NumSubordinates(NS),
    .SubordinateAddrBits(SAB), .TimeoutCycles(TO)
  ) dut (
    .pclk_i(clk), .presetn_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_error_o(resp_error), .resp_timeout_o(resp_timeout),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    bit            tout;
    int            lat;
    int            n_setup;
    int            n_acc;
    int            acc_edge;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            plan_idx = 0;
  int            plan_w = 0;
  bit            plan_err = 1'b0;
  bit            plan_wr = 1'b0;
  logic [DW-1:0] plan_data = '0;
  logic [DW-1:0] plan_wdata = '0;
  logic [AW-1:0] plan_addr = '0;
  int            rr_mode = 1;
  int            acc_cnt = 0;
  int            n_setup = 0;
  int            n_acc = 0;
  bit            prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one transfer from the decode/wait/error plan.
  function automatic exp_t model(input int idx, input bit wr, input int w, input bit e,
                                 input logic [DW-1:0] d, input int acc_edge);
    exp_t x;
    x.acc_edge = acc_edge;
    if (idx >= NS) begin
      x.rdata = '0; x.err = 1'b1; x.tout = 1'b0; x.lat = 0; x.n_setup = 0; x.n_acc = 0;
    end else if (w >= TO) begin
      x.rdata = '0; x.err = 1'b1; x.tout = 1'b1; x.lat = TO + 1; x.n_setup = 1; x.n_acc = TO;
    end else begin
      x.rdata = (!wr && !e) ? d : '0; x.err = e; x.tout = 1'b0;
      x.lat = w + 2; x.n_setup = 1; x.n_acc = w + 1;
    end
    return x;
  endfunction

  function automatic logic [NS-1:0] exp_sel(input int idx);
    logic [NS-1:0] s;
    s = '0;
    if (idx < NS) s[idx] = 1'b1;
    return s;
  endfunction

  task automatic issue(input int idx, input logic [15:0] offs, input bit wr, input logic [DW-1:0] wd,
                       input int w, input bit e, input logic [DW-1:0] d, input bit expect_resp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: req_ready 0 after %0d cycles, required 1", n);
      return;
    end
    plan_idx   = idx;
    plan_w     = w;
    plan_err   = e;
    plan_wr    = wr;
    plan_data  = d;
    plan_wdata = wd;
    plan_addr  = {idx[3:0], offs};
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = plan_addr;
    req_wdata  = wd;
    if (expect_resp) sb_q.push_back(model(idx, wr, w, e, d, cyc + 1));
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_write = 1'($urandom);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !req_ready) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || !req_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d responses outstanding after %0d cycles, required 0", sb_q.size(), n);
    end
  endtask

  // Subordinate responder: non-selected lanes carry random noise every cycle.
  initial forever begin
    @(negedge clk);
    if (penable && psel != '0) acc_cnt++;
    else acc_cnt = 0;
    for (int i = 0; i < NS; i++) begin
      pready[i]             = 1'($urandom);
      pslverr[i]            = 1'($urandom);
      prdata[i*DW +: DW]    = $urandom;
    end
    if (acc_cnt > 0 && plan_idx < NS) begin
      pready[plan_idx]          = (acc_cnt == plan_w + 1);
      pslverr[plan_idx]         = plan_err;
      prdata[plan_idx*DW +: DW] = plan_data;
    end
    case (rr_mode)
      0:       resp_ready = ($urandom_range(0, 3) != 0);
      1:       resp_ready = 1'b1;
      default: resp_ready = 1'b0;
    endcase
  end

  // Monitor: bus protocol checks and scoreboard compare on every presented response.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      n_setup    = 0;
      n_acc      = 0;
      prev_valid = 1'b0;
    end else begin
      if (psel != '0) begin
        chk("psel_onehot", psel, exp_sel(plan_idx));
        chk("paddr_stable", paddr, plan_addr);
        chk("pwrite_stable", pwrite, plan_wr);
        chk("pwdata_stable", pwdata, plan_wdata);
        chk("req_ready_busy", req_ready, 0);
        if (penable) n_acc++;
        else n_setup++;
      end else if (penable) begin
        chk("penable_no_psel", penable, 0);
      end
      if (resp_valid) begin
        chk("resp_bus_idle", {penable, psel}, 0);
        chk("req_ready_in_resp", req_ready, 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: resp_valid 1 with no outstanding request, required 0");
        end else begin
          if (!prev_valid) begin
            chk("latency", 64'(cyc - sb_q[0].acc_edge), 64'(sb_q[0].lat));
            chk("setup_cycles", 64'(n_setup), 64'(sb_q[0].n_setup));
            chk("access_cycles", 64'(n_acc), 64'(sb_q[0].n_acc));
            n_setup = 0;
            n_acc   = 0;
          end
          chk("resp_rdata", resp_rdata, sb_q[0].rdata);
          chk("resp_error", resp_error, sb_q[0].err);
          chk("resp_timeout", resp_timeout, sb_q[0].tout);
          if (resp_ready) void'(sb_q.pop_front());
        end
      end
      prev_valid = resp_valid && !resp_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, idx, w;
    bit wr, e;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outs", {req_ready, resp_valid, resp_error, resp_timeout, penable, pwrite, psel, paddr}, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_pwdata", pwdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", req_ready, 1);

    rr_mode = 1;
    issue(2, 16'h0010, 1'b0, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(1, 16'h0004, 1'b1, 32'h12345678, 3, 1'b1, 32'hA5A5A5A5, 1'b1);
    issue(5, 16'h0000, 1'b0, 32'h0, 0, 1'b0, 32'h11111111, 1'b1);
    issue(3, 16'h0100, 1'b0, 32'h0, 100, 1'b0, 32'h22222222, 1'b1);
    issue(0, 16'h0008, 1'b0, 32'h0, 1, 1'b0, 32'hCAFEF00D, 1'b1);
    issue(2, 16'h0020, 1'b0, 32'h0, TO - 1, 1'b0, 32'h0BADCAFE, 1'b1);
    wait_idle(200);

    rr_mode = 2;
    issue(1, 16'h0030, 1'b0, 32'h0, 2, 1'b0, 32'h13572468, 1'b1);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("backpressure_hold", {resp_valid, req_ready}, 2'b10);
    rr_mode = 1;
    wait_idle(200);

    rr_mode = 0;
    for (int t = 0; t < 60; t++) begin
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, NS - 1));
      w   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 3)) : int'($urandom_range(0, TO - 1));
      wr  = 1'($urandom);
      e   = ($urandom_range(0, 3) == 0);
      issue(idx, 16'($urandom), wr, $urandom, w, e, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 1;
    wait_idle(2000);

    issue(1, 16'h0040, 1'b0, $urandom, 6, 1'b0, $urandom, 1'b0);
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_in_access", penable, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_ctrl_outs", {req_ready, resp_valid, resp_error, resp_timeout, penable, pwrite, psel, paddr}, 0);
    chk("midreset_rdata", resp_rdata, 0);
    chk("midreset_pwdata", pwdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_release_ready", req_ready, 1);
    repeat (12) @(negedge clk);
    chk("midreset_no_stale_resp", resp_valid, 0);

    issue(3, 16'h0044, 1'b0, 32'h0, 0, 1'b0, 32'h600DF00D, 1'b1);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
